// File: rtl/sd_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_loader_pkg : shared types and constants for the SD sector block loader
// Rev 1.0
// ---------------------------------------------------------------------------
package sd_loader_pkg;

   localparam int WORDS_PER_SECTOR   = 128;
   localparam int BYTES_PER_SECTOR   = WORDS_PER_SECTOR * 4;
   localparam int SECTOR_ADDR_W      = $clog2(BYTES_PER_SECTOR);
   localparam int DEFAULT_FIFO_DEPTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RECEIVE   = 3'd3,
      ST_DRAIN     = 3'd4
   } sd_state_e;

endpackage
`default_nettype wire

// File: rtl/sd_block_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_block_loader_if : SD reader stream and memory write port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface sd_block_loader_if;
   import sd_loader_pkg::*;

   logic                     rstart;
   logic [31:0]              rsector_no;
   logic                     rbusy;
   logic                     rdone;
   logic                     outreq;
   logic [SECTOR_ADDR_W-1:0] outaddr;
   logic [7:0]               outbyte;
   logic                     wr_valid;
   logic                     wr_ready;
   logic [31:0]              wr_addr;
   logic [31:0]              wr_data;

   // master = loader side, slave = reader + memory side
   modport master (
      output rstart, rsector_no, wr_valid, wr_addr, wr_data,
      input  rbusy, rdone, outreq, outaddr, outbyte, wr_ready
   );

   modport slave (
      input  rstart, rsector_no, wr_valid, wr_addr, wr_data,
      output rbusy, rdone, outreq, outaddr, outbyte, wr_ready
   );

endinterface
`default_nettype wire

// File: rtl/sd_word_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_word_fifo : synchronous word FIFO, simultaneous push/pop allowed at full
// Rev 1.0
// ---------------------------------------------------------------------------
module sd_word_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE  = 1;
   localparam logic [AW:0]    CNT_ONE  = 1;
   localparam logic [AW:0]    CNT_FULL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   // a pop frees a slot in the same cycle, so a push at full still lands
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_ONE;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sd_block_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_block_loader : reads a range of SD sectors and writes them to memory
// Rev 1.0
// ---------------------------------------------------------------------------
module sd_block_loader
   import sd_loader_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] start_sector,
   input  logic [15:0] num_sectors,
   input  logic [31:0] dst_addr,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [15:0] sectors_done,
   sd_block_loader_if.master bus
);

   localparam logic [2:0] S_IDLE      = 3'(ST_IDLE);
   localparam logic [2:0] S_ISSUE     = 3'(ST_ISSUE);
   localparam logic [2:0] S_WAIT_BUSY = 3'(ST_WAIT_BUSY);
   localparam logic [2:0] S_RECEIVE   = 3'(ST_RECEIVE);
   localparam logic [2:0] S_DRAIN     = 3'(ST_DRAIN);

   logic [2:0]  state_q, state_d;
   logic [31:0] start_sector_q, start_sector_d;
   logic [15:0] num_sectors_q, num_sectors_d;
   logic [31:0] dst_addr_q, dst_addr_d;
   logic [15:0] sectors_done_q, sectors_done_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        overflow_q, overflow_d;
   logic        rstart_q, rstart_d;
   logic [31:0] rsector_no_q, rsector_no_d;
   logic [31:0] pack_q, pack_d;
   logic [23:0] words_popped_q, words_popped_d;

   logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [31:0] fifo_head, push_word;
   logic        unused_outaddr;

   assign unused_outaddr = ^bus.outaddr[SECTOR_ADDR_W-1:2];
   assign fifo_pop       = !fifo_empty && bus.wr_ready;
   assign push_word      = {bus.outbyte, pack_q[23:0]};

   sd_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (push_word),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   always_comb begin
      state_d        = state_q;
      start_sector_d = start_sector_q;
      num_sectors_d  = num_sectors_q;
      dst_addr_d     = dst_addr_q;
      sectors_done_d = sectors_done_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      overflow_d     = overflow_q;
      rstart_d       = 1'b0;
      rsector_no_d   = rsector_no_q;
      pack_d         = pack_q;
      words_popped_d = words_popped_q;
      fifo_push      = 1'b0;

      if (fifo_pop) begin
         words_popped_d = words_popped_q + 24'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_sector_d = start_sector;
               num_sectors_d  = num_sectors;
               dst_addr_d     = dst_addr;
               sectors_done_d = '0;
               words_popped_d = '0;
               overflow_d     = 1'b0;
               pack_d         = '0;
               // an empty range completes immediately without touching the reader
               if (num_sectors == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (!bus.rbusy) begin
               rstart_d     = 1'b1;
               rsector_no_d = start_sector_q + {16'd0, sectors_done_q};
               state_d      = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (bus.rbusy) begin
               state_d = S_RECEIVE;
            end
         end
         S_RECEIVE: begin
            if (bus.outreq) begin
               case (bus.outaddr[1:0])
                  2'd0:    pack_d[7:0]   = bus.outbyte;
                  2'd1:    pack_d[15:8]  = bus.outbyte;
                  2'd2:    pack_d[23:16] = bus.outbyte;
                  default: begin
                     pack_d[31:24] = bus.outbyte;
                     fifo_push     = 1'b1;
                  end
               endcase
            end
            if (bus.rdone) begin
               sectors_done_d = sectors_done_q + 16'd1;
               state_d = (sectors_done_d == num_sectors_q) ? S_DRAIN : S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (fifo_empty) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fifo_push && fifo_full && !fifo_pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         start_sector_q <= '0;
         num_sectors_q  <= '0;
         dst_addr_q     <= '0;
         sectors_done_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         overflow_q     <= 1'b0;
         rstart_q       <= 1'b0;
         rsector_no_q   <= '0;
         pack_q         <= '0;
         words_popped_q <= '0;
      end else begin
         state_q        <= state_d;
         start_sector_q <= start_sector_d;
         num_sectors_q  <= num_sectors_d;
         dst_addr_q     <= dst_addr_d;
         sectors_done_q <= sectors_done_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         overflow_q     <= overflow_d;
         rstart_q       <= rstart_d;
         rsector_no_q   <= rsector_no_d;
         pack_q         <= pack_d;
         words_popped_q <= words_popped_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign overflow       = overflow_q;
   assign sectors_done   = sectors_done_q;
   assign bus.rstart     = rstart_q;
   assign bus.rsector_no = rsector_no_q;
   assign bus.wr_valid   = !fifo_empty;
   assign bus.wr_data    = fifo_head;
   assign bus.wr_addr    = dst_addr_q + {6'd0, words_popped_q, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_sd_block_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sd_block_loader : scoreboard bench with an SD reader model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sd_block_loader;
   import sd_loader_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] start_sector = '0;
   logic [15:0] num_sectors = '0;
   logic [31:0] dst_addr = '0;
   logic        busy, done, overflow;
   logic [15:0] sectors_done;

   sd_block_loader_if bus();

   sd_block_loader #(.FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .start_sector (start_sector),
      .num_sectors  (num_sectors),
      .dst_addr     (dst_addr),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .sectors_done (sectors_done),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          rstart_cnt = 0;
   int          wr_cnt = 0;
   int          rdy_mode = 1;
   int          exp_idx = 0;
   logic [31:0] exp_base = '0;
   logic [31:0] first_addr, first_data, last_addr, last_data;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data, prev_addr;
   wr_t         exp_q[$];
   wr_t         mon_e;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // write-ready pattern generator
   initial begin
      bus.wr_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       bus.wr_ready = 1'b0;
            1:       bus.wr_ready = 1'b1;
            default: bus.wr_ready = ~bus.wr_ready;
         endcase
      end
   end

   // monitor: scoreboard pops, stall stability, pulse counters
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (bus.rstart) rstart_cnt++;
         if (prev_stall) begin
            check_val("stall_valid", 32'(bus.wr_valid), 32'd1);
            check_val("stall_data", bus.wr_data, prev_data);
            check_val("stall_addr", bus.wr_addr, prev_addr);
         end
         if (bus.wr_valid && bus.wr_ready) begin
            check_val("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check_val("wr_addr", bus.wr_addr, mon_e.addr);
               check_val("wr_data", bus.wr_data, mon_e.data);
            end
            if (wr_cnt == 0) begin
               first_addr = bus.wr_addr;
               first_data = bus.wr_data;
            end
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
            wr_cnt++;
         end
         prev_stall = bus.wr_valid && !bus.wr_ready;
         prev_data  = bus.wr_data;
         prev_addr  = bus.wr_addr;
      end
   end

   task automatic do_start(input logic [31:0] sec, input logic [15:0] n, input logic [31:0] dst);
      start_sector = sec;
      num_sectors  = n;
      dst_addr     = dst;
      start        = 1'b1;
      exp_base     = dst;
      exp_idx      = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // reader model: waits for rstart, streams nbytes, expects the first keep words
   task automatic read_sector(input logic [31:0] exp_sec, input logic [7:0] seq,
                              input int nbytes, input int keep, input bit ovf_chk);
      logic [31:0] w;
      logic [7:0]  b;
      int          n;
      int          n_words;
      w = '0;
      n = 0;
      n_words = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rstart && n < 200);
      check_val("rstart_seen", 32'(bus.rstart), 32'd1);
      check_val("rsector_no", bus.rsector_no, exp_sec);
      @(posedge clk); #1;
      bus.rbusy = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < nbytes; i++) begin
         b = 8'(i) + seq;
         bus.outreq  = 1'b1;
         bus.outaddr = 9'(i);
         bus.outbyte = b;
         w[8*(i%4) +: 8] = b;
         if (i % 4 == 3) begin
            if (n_words < keep) begin
               exp_q.push_back(wr_t'{addr: exp_base + 32'(exp_idx * 4), data: w});
               exp_idx++;
            end
            n_words++;
         end
         @(posedge clk); #1;
         if (ovf_chk && i == 31) check_val("ovf_at_8th", 32'(overflow), 32'd0);
         if (ovf_chk && i == 35) check_val("ovf_at_9th", 32'(overflow), 32'd1);
      end
      bus.outreq = 1'b0;
      if (nbytes == BYTES_PER_SECTOR) begin
         bus.rdone = 1'b1;
         @(posedge clk); #1;
         bus.rdone = 1'b0;
         bus.rbusy = 1'b0;
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val("done_seen", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_done"}, 32'(done), 32'd0);
      check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
      check_val({tag, "_rstart"}, 32'(bus.rstart), 32'd0);
      check_val({tag, "_wrvalid"}, 32'(bus.wr_valid), 32'd0);
      check_val({tag, "_secdone"}, 32'(sectors_done), 32'd0);
      check_val({tag, "_rsector"}, bus.rsector_no, 32'd0);
      check_val({tag, "_wraddr"}, bus.wr_addr, 32'd0);
      check_val({tag, "_wrdata"}, bus.wr_data, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0;
      bus.rbusy   = 1'b0;
      bus.rdone   = 1'b0;
      bus.outreq  = 1'b0;
      bus.outaddr = '0;
      bus.outbyte = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      rdy_mode = 1;
      repeat (2) @(posedge clk); #1;

      // single sector, continuous ready
      wr_cnt = 0; d0 = done_cnt; r0 = rstart_cnt;
      do_start(32'd5, 16'd1, 32'h1000);
      read_sector(32'd5, 8'd0, BYTES_PER_SECTOR, WORDS_PER_SECTOR, 1'b0);
      wait_done(200);
      check_val("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
      check_val("t1_rstart_cnt", 32'(rstart_cnt - r0), 32'd1);
      check_val("t1_wr_cnt", 32'(wr_cnt), 32'd128);
      check_val("t1_first_data", first_data, 32'h03020100);
      check_val("t1_first_addr", first_addr, 32'h00001000);
      check_val("t1_last_data", last_data, 32'hFFFEFDFC);
      check_val("t1_last_addr", last_addr, 32'h000011FC);
      check_val("t1_sb_empty", 32'(exp_q.size()), 32'd0);
      check_val("t1_busy", 32'(busy), 32'd0);

      // sector number wrap, plus a start while busy
      wr_cnt = 0; d0 = done_cnt; r0 = rstart_cnt;
      do_start(32'hFFFF_FFFF, 16'd3, 32'h2000);
      check_val("t2_busy", 32'(busy), 32'd1);
      start_sector = 32'h55; num_sectors = 16'd1; dst_addr = 32'h9000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      read_sector(32'hFFFF_FFFF, 8'd1, BYTES_PER_SECTOR, WORDS_PER_SECTOR, 1'b0);
      read_sector(32'h0000_0000, 8'd2, BYTES_PER_SECTOR, WORDS_PER_SECTOR, 1'b0);
      read_sector(32'h0000_0001, 8'd3, BYTES_PER_SECTOR, WORDS_PER_SECTOR, 1'b0);
      wait_done(200);
      check_val("t2_secdone", 32'(sectors_done), 32'd3);
      check_val("t2_rstart_cnt", 32'(rstart_cnt - r0), 32'd3);
      check_val("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
      check_val("t2_wr_cnt", 32'(wr_cnt), 32'd384);
      check_val("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // memory stalled for a whole sector: FIFO fills, extra words dropped
      rdy_mode = 0;
      @(posedge clk); #1;
      wr_cnt = 0; d0 = done_cnt;
      do_start(32'd10, 16'd1, 32'h3000);
      read_sector(32'd10, 8'd4, BYTES_PER_SECTOR, 8, 1'b1);
      repeat (3) @(posedge clk); #1;
      check_val("t3_ovf", 32'(overflow), 32'd1);
      check_val("t3_held", 32'(bus.wr_valid), 32'd1);
      check_val("t3_no_writes", 32'(wr_cnt), 32'd0);
      check_val("t3_no_done", 32'(done_cnt - d0), 32'd0);
      rdy_mode = 1;
      wait_done(100);
      check_val("t3_wr_cnt", 32'(wr_cnt), 32'd8);
      check_val("t3_ovf_sticky", 32'(overflow), 32'd1);
      check_val("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // ready toggling every cycle
      rdy_mode = 2;
      wr_cnt = 0; d0 = done_cnt;
      do_start(32'd20, 16'd2, 32'h4000);
      check_val("t4_ovf_cleared", 32'(overflow), 32'd0);
      read_sector(32'd20, 8'd5, BYTES_PER_SECTOR, WORDS_PER_SECTOR, 1'b0);
      read_sector(32'd21, 8'd6, BYTES_PER_SECTOR, WORDS_PER_SECTOR, 1'b0);
      wait_done(200);
      check_val("t4_ovf", 32'(overflow), 32'd0);
      check_val("t4_wr_cnt", 32'(wr_cnt), 32'd256);
      check_val("t4_sb_empty", 32'(exp_q.size()), 32'd0);
      rdy_mode = 1;

      // zero-length load
      d0 = done_cnt; r0 = rstart_cnt;
      start_sector = 32'd77; num_sectors = 16'd0; dst_addr = 32'h7000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_val("t5_done", 32'(done), 32'd1);
      check_val("t5_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check_val("t5_done_low", 32'(done), 32'd0);
      check_val("t5_busy_low", 32'(busy), 32'd0);
      repeat (5) @(posedge clk); #1;
      check_val("t5_no_rstart", 32'(rstart_cnt - r0), 32'd0);
      check_val("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

      // reset in the middle of sector 2 of 4
      do_start(32'd100, 16'd4, 32'h5000);
      read_sector(32'd100, 8'd7, BYTES_PER_SECTOR, WORDS_PER_SECTOR, 1'b0);
      read_sector(32'd101, 8'd8, 200, WORDS_PER_SECTOR, 1'b0);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 24; i++) begin
         bus.outreq  = 1'b1;
         bus.outaddr = 9'(i);
         bus.outbyte = 8'(i);
         bus.rdone   = (i == 23);
         @(posedge clk); #1;
      end
      bus.outreq = 1'b0;
      bus.rdone  = 1'b0;
      bus.rbusy  = 1'b0;
      repeat (3) @(posedge clk); #1;
      check_val("t6_ignored_wr", 32'(bus.wr_valid), 32'd0);
      check_val("t6_ignored_busy", 32'(busy), 32'd0);
      check_val("t6_no_done", 32'(done_cnt - d0), 32'd0);
      wr_cnt = 0; d0 = done_cnt;
      do_start(32'd200, 16'd1, 32'h6000);
      read_sector(32'd200, 8'd9, BYTES_PER_SECTOR, WORDS_PER_SECTOR, 1'b0);
      wait_done(200);
      check_val("t6_wr_cnt", 32'(wr_cnt), 32'd128);
      check_val("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
      check_val("t6_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
